t_ff_bank: RTL and testbench



---
 rtl/t_ff_bank.sv | 78 +++++++
 tb/tb_t_ff_bank.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops with per-bit toggle, chained-T up/down count,
// synchronous parallel load, and registered wrap/change pulses.
module t_ff_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             chg
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    mode_e            mode_op;
    logic [WIDTH-1:0] tog;
    logic             wrap_d;
    logic             run;

    assign mode_op = mode_e'(mode);

    // Chained T: each bit toggles when every lower bit is 1 (up) or 0 (down);
    // a wrap occurs exactly when the chain reaches past the top bit.
    always_comb begin
        tog    = '0;
        wrap_d = 1'b0;
        run    = 1'b1;
        case (mode_op)
            MODE_TOGGLE: tog = t;
            MODE_UP: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    tog[i] = run;
                    run    = run & q[i];
                end
                wrap_d = run;
            end
            MODE_DOWN: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    tog[i] = run;
                    run    = run & ~q[i];
                end
                wrap_d = run;
            end
            default: tog = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
            chg  <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            wrap <= 1'b0;
            chg  <= (load_val != q);
        end else if (en) begin
            q    <= q ^ tog;
            wrap <= wrap_d;
            chg  <= |tog;
        end else begin
            wrap <= 1'b0;
            chg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_t_ff_bank.sv
// Directed test of t_ff_bank at WIDTH=4, with a second instance built with
// RESET_VAL=4'h9 sharing the same stimulus to check the reset value.
module tb_t_ff_bank;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       wrap;
    logic       chg;
    logic [3:0] q9;
    logic       wrap9;
    logic       chg9;

    int unsigned checks = 0;
    int unsigned errors = 0;

    t_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .t(t),
        .load(load), .load_val(load_val), .q(q), .wrap(wrap), .chg(chg)
    );

    t_ff_bank #(.WIDTH(4), .RESET_VAL(4'h9)) dut9 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .t(t),
        .load(load), .load_val(load_val), .q(q9), .wrap(wrap9), .chg(chg9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eq, input logic ew, input logic ec);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
        check({tag, ".chg"}, 32'(chg), 32'(ec));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        mode     = 2'b00;
        t        = 4'h0;
        load     = 1'b0;
        load_val = 4'h0;
        step();
        step();
        expect_out("rst_init", 4'h0, 1'b0, 1'b0);
        check("rst_init.q9", 32'(q9), 32'h9);
        reset_n = 1'b1;

        // 1. asynchronous reset mid-cycle from q=A
        load = 1'b1; load_val = 4'hA;
        step();
        load = 1'b0;
        expect_out("load_a", 4'hA, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        expect_out("async_rst", 4'h0, 1'b0, 1'b0);
        check("async_rst.q9", 32'(q9), 32'h9);
        #2 reset_n = 1'b1;
        step();
        expect_out("rst_rel1", 4'h0, 1'b0, 1'b0);
        step();
        expect_out("rst_rel2", 4'h0, 1'b0, 1'b0);

        // 2. per-bit toggle
        mode = 2'b01; en = 1'b1; t = 4'b0101;
        step(); expect_out("tog1", 4'h5, 1'b0, 1'b1);
        step(); expect_out("tog2", 4'h0, 1'b0, 1'b1);
        step(); expect_out("tog3", 4'h5, 1'b0, 1'b1);
        t = 4'h0;
        step(); expect_out("tog_t0a", 4'h5, 1'b0, 1'b0);
        step(); expect_out("tog_t0b", 4'h5, 1'b0, 1'b0);

        // 3. count up with wrap
        en = 1'b0; load = 1'b1; load_val = 4'hE;
        step(); expect_out("ld_e", 4'hE, 1'b0, 1'b1);
        load = 1'b0; mode = 2'b10; en = 1'b1;
        step(); expect_out("up1", 4'hF, 1'b0, 1'b1);
        step(); expect_out("up_wrap", 4'h0, 1'b1, 1'b1);
        step(); expect_out("up3", 4'h1, 1'b0, 1'b1);
        en = 1'b0;
        step(); expect_out("up_hold1", 4'h1, 1'b0, 1'b0);
        step(); expect_out("up_hold2", 4'h1, 1'b0, 1'b0);

        // 4. count down with wrap (load of the value already held gives no chg)
        load = 1'b1; load_val = 4'h1;
        step(); expect_out("ld_1_same", 4'h1, 1'b0, 1'b0);
        load = 1'b0; mode = 2'b11; en = 1'b1;
        step(); expect_out("dn1", 4'h0, 1'b0, 1'b1);
        step(); expect_out("dn_wrap", 4'hF, 1'b1, 1'b1);
        step(); expect_out("dn3", 4'hE, 1'b0, 1'b1);

        // mode 00 with en=1 holds
        mode = 2'b00;
        step(); expect_out("mode00", 4'hE, 1'b0, 1'b0);

        // 5. load beats count
        en = 1'b0; load = 1'b1; load_val = 4'h7;
        step(); expect_out("ld_7", 4'h7, 1'b0, 1'b1);
        mode = 2'b10; en = 1'b1; load_val = 4'h3;
        step(); expect_out("prio", 4'h3, 1'b0, 1'b1);
        step(); expect_out("prio_same", 4'h3, 1'b0, 1'b0);

        // 6. reset just before the wrapping edge
        en = 1'b0; load_val = 4'hF;
        step(); expect_out("ld_f", 4'hF, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1; mode = 2'b10;
        #3 reset_n = 1'b0;
        @(posedge clk); #1;
        expect_out("rst_cnt", 4'h0, 1'b0, 1'b0);
        check("rst_cnt.q9", 32'(q9), 32'h9);
        check("rst_cnt.wrap9", 32'(wrap9), 32'h0);
        #2 reset_n = 1'b1;
        step(); expect_out("post_rst_up", 4'h1, 1'b0, 1'b1);
        check("post_rst_up.q9", 32'(q9), 32'hA);
        check("post_rst_up.chg9", 32'(chg9), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
